ysyx_23060124_wbu: RTL and testbench

//  Write-back stage directly downstream of the execute stage. Accepts one retired instruction per

---
 rtl/ysyx_23060124_wbu_pkg.sv | 36 +++
 rtl/ysyx_23060124_wbu_if.sv | 61 ++++++
 rtl/ysyx_23060124_wbu_npc.sv | 42 ++++
 rtl/ysyx_23060124_wbu.sv | 141 ++++++++++++++
 tb/tb_ysyx_23060124_wbu.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060124_wbu_pkg.sv
// Shared widths, FSM encodings and the captured-instruction record for the write-back stage.
package ysyx_23060124_wbu_pkg;

  localparam int ISA_WIDTH = 32;
  localparam int REG_AW    = 5;
  localparam int CSR_AW    = 12;

  // Cause code written by the trap CSR path when an ecall retires from M-mode.
  localparam logic [ISA_WIDTH-1:0] MCAUSE_ECALL_M = 32'd11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_WAIT   = 2'd2
  } wbu_state_e;

  typedef struct packed {
    logic [ISA_WIDTH-1:0] pc;
    logic [ISA_WIDTH-1:0] imm;
    logic [ISA_WIDTH-1:0] src1;
    logic [ISA_WIDTH-1:0] res;
    logic [REG_AW-1:0]    rd;
    logic                 rd_wen;
    logic                 csr_wen;
    logic [CSR_AW-1:0]    csr_addr;
    logic [ISA_WIDTH-1:0] csr_wdata;
    logic                 brch;
    logic                 jal;
    logic                 jalr;
    logic                 ecall;
    logic                 mret;
    logic [ISA_WIDTH-1:0] mtvec;
    logic [ISA_WIDTH-1:0] mepc;
  } wbu_inst_t;

endpackage

// File: rtl/ysyx_23060124_wbu_if.sv
// Bundle of all write-back stage signals: EXU-side inputs, register-file/CSR writes, IFU next-PC.
// YSYX_23060124_WBU_PERF_EN adds the retire/stall counter outputs.
interface ysyx_23060124_wbu_if;
  import ysyx_23060124_wbu_pkg::*;

  logic                 pre_valid;
  logic                 pre_ready;
  logic [ISA_WIDTH-1:0] res;
  logic [ISA_WIDTH-1:0] pc;
  logic [ISA_WIDTH-1:0] imm;
  logic [ISA_WIDTH-1:0] src1;
  logic [REG_AW-1:0]    rd;
  logic                 rd_wen;
  logic                 csr_wen;
  logic [CSR_AW-1:0]    csr_addr;
  logic [ISA_WIDTH-1:0] csr_wdata;
  logic                 brch;
  logic                 jal;
  logic                 jalr;
  logic                 ecall;
  logic                 mret;
  logic [ISA_WIDTH-1:0] mtvec;
  logic [ISA_WIDTH-1:0] mepc;

  logic                 wb_rd_wen;
  logic [REG_AW-1:0]    wb_rd_addr;
  logic [ISA_WIDTH-1:0] wb_rd_wdata;
  logic                 wb_csr_wen;
  logic [CSR_AW-1:0]    wb_csr_addr;
  logic [ISA_WIDTH-1:0] wb_csr_wdata;
  logic                 trap_wen;
  logic [ISA_WIDTH-1:0] mepc_wdata;
  logic [ISA_WIDTH-1:0] npc;
  logic                 post_valid;
  logic                 post_ready;
`ifdef YSYX_23060124_WBU_PERF_EN
  logic [63:0]          retire_cnt;
  logic [31:0]          stall_cnt;
`endif

  modport master (
    output pre_valid, res, pc, imm, src1, rd, rd_wen, csr_wen, csr_addr, csr_wdata,
           brch, jal, jalr, ecall, mret, mtvec, mepc, post_ready,
    input  pre_ready, wb_rd_wen, wb_rd_addr, wb_rd_wdata, wb_csr_wen, wb_csr_addr,
           wb_csr_wdata, trap_wen, mepc_wdata, npc, post_valid
`ifdef YSYX_23060124_WBU_PERF_EN
           , retire_cnt, stall_cnt
`endif
  );

  modport slave (
    input  pre_valid, res, pc, imm, src1, rd, rd_wen, csr_wen, csr_addr, csr_wdata,
           brch, jal, jalr, ecall, mret, mtvec, mepc, post_ready,
    output pre_ready, wb_rd_wen, wb_rd_addr, wb_rd_wdata, wb_csr_wen, wb_csr_addr,
           wb_csr_wdata, trap_wen, mepc_wdata, npc, post_valid
`ifdef YSYX_23060124_WBU_PERF_EN
           , retire_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/ysyx_23060124_wbu_npc.sv
// Combinational next-PC select from the captured instruction fields.
module ysyx_23060124_wbu_npc
  import ysyx_23060124_wbu_pkg::*;
(
  input  logic [ISA_WIDTH-1:0] pc,
  input  logic [ISA_WIDTH-1:0] imm,
  input  logic [ISA_WIDTH-1:0] src1,
  input  logic                 taken,
  input  logic                 brch,
  input  logic                 jal,
  input  logic                 jalr,
  input  logic                 ecall,
  input  logic                 mret,
  input  logic [ISA_WIDTH-1:0] mtvec,
  input  logic [ISA_WIDTH-1:0] mepc,
  output logic [ISA_WIDTH-1:0] npc
);

  localparam logic [ISA_WIDTH-1:0] JALR_MASK = {{(ISA_WIDTH-1){1'b1}}, 1'b0};

  logic [ISA_WIDTH-1:0] seq_pc;
  logic [ISA_WIDTH-1:0] rel_pc;
  logic [ISA_WIDTH-1:0] reg_pc;

  // All sums wrap at ISA_WIDTH bits.
  assign seq_pc = pc + ISA_WIDTH'(4);
  assign rel_pc = pc + imm;
  assign reg_pc = (src1 + imm) & JALR_MASK;

  always_comb begin
    npc = seq_pc;
    if (ecall)
      npc = mtvec;
    else if (mret)
      npc = mepc;
    else if (jalr)
      npc = reg_pc;
    else if (jal || (brch && taken))
      npc = rel_pc;
  end

endmodule

// File: rtl/ysyx_23060124_wbu.sv
// Write-back stage: captures one retired instruction, commits GPR/CSR/trap writes for one cycle,
// then offers the next PC to fetch. YSYX_23060124_WBU_PERF_EN adds retire/stall counters.
module ysyx_23060124_wbu
  import ysyx_23060124_wbu_pkg::*;
(
  input  logic               clk,
  input  logic               i_rst,
  ysyx_23060124_wbu_if.slave bus
);

  wbu_state_e           state_reg;
  wbu_state_e           state_next;
  wbu_inst_t            inst_reg;
  logic [ISA_WIDTH-1:0] npc_sel;

  logic                 pre_ready;
  logic                 post_valid;
  logic                 in_commit;
  logic                 rd_wen_out;
  logic                 csr_wen_out;
  logic                 trap_wen_out;
  logic [ISA_WIDTH-1:0] npc_out;

  // State register.
  always_ff @(posedge clk) begin
    if (i_rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.pre_valid) state_next = S_COMMIT;
      S_COMMIT: state_next = bus.post_ready ? S_IDLE : S_WAIT;
      S_WAIT:   if (bus.post_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic: write strobes only in COMMIT so a stalled IFU never causes a second write.
  always_comb begin
    pre_ready    = 1'b0;
    post_valid   = 1'b0;
    in_commit    = 1'b0;
    rd_wen_out   = 1'b0;
    csr_wen_out  = 1'b0;
    trap_wen_out = 1'b0;
    npc_out      = '0;
    case (state_reg)
      S_IDLE: pre_ready = 1'b1;
      S_COMMIT: begin
        in_commit    = 1'b1;
        post_valid   = 1'b1;
        rd_wen_out   = inst_reg.rd_wen && (inst_reg.rd != '0);
        csr_wen_out  = inst_reg.csr_wen;
        trap_wen_out = inst_reg.ecall;
        npc_out      = npc_sel;
      end
      S_WAIT: begin
        post_valid = 1'b1;
        npc_out    = npc_sel;
      end
      default: pre_ready = 1'b0;
    endcase
  end

  // Capture every field on the accepting edge; held unchanged until the next accept.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      inst_reg <= '0;
    end else if (bus.pre_valid && pre_ready) begin
      inst_reg.pc        <= bus.pc;
      inst_reg.imm       <= bus.imm;
      inst_reg.src1      <= bus.src1;
      inst_reg.res       <= bus.res;
      inst_reg.rd        <= bus.rd;
      inst_reg.rd_wen    <= bus.rd_wen;
      inst_reg.csr_wen   <= bus.csr_wen;
      inst_reg.csr_addr  <= bus.csr_addr;
      inst_reg.csr_wdata <= bus.csr_wdata;
      inst_reg.brch      <= bus.brch;
      inst_reg.jal       <= bus.jal;
      inst_reg.jalr      <= bus.jalr;
      inst_reg.ecall     <= bus.ecall;
      inst_reg.mret      <= bus.mret;
      inst_reg.mtvec     <= bus.mtvec;
      inst_reg.mepc      <= bus.mepc;
    end
  end

  ysyx_23060124_wbu_npc u_npc (
    .pc    (inst_reg.pc),
    .imm   (inst_reg.imm),
    .src1  (inst_reg.src1),
    .taken (inst_reg.res[0]),
    .brch  (inst_reg.brch),
    .jal   (inst_reg.jal),
    .jalr  (inst_reg.jalr),
    .ecall (inst_reg.ecall),
    .mret  (inst_reg.mret),
    .mtvec (inst_reg.mtvec),
    .mepc  (inst_reg.mepc),
    .npc   (npc_sel)
  );

  assign bus.pre_ready    = pre_ready;
  assign bus.post_valid   = post_valid;
  assign bus.npc          = npc_out;
  assign bus.wb_rd_wen    = rd_wen_out;
  assign bus.wb_rd_addr   = inst_reg.rd;
  assign bus.wb_rd_wdata  = inst_reg.res;
  assign bus.wb_csr_wen   = csr_wen_out;
  assign bus.wb_csr_addr  = inst_reg.csr_addr;
  assign bus.wb_csr_wdata = inst_reg.csr_wdata;
  assign bus.trap_wen     = trap_wen_out;
  assign bus.mepc_wdata   = inst_reg.pc;

`ifdef YSYX_23060124_WBU_PERF_EN
  logic [63:0] retire_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      retire_cnt_reg <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      if (in_commit)
        retire_cnt_reg <= retire_cnt_reg + 64'd1;
      if (state_reg == S_WAIT)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.retire_cnt = retire_cnt_reg;
  assign bus.stall_cnt  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Directed bench for the write-back stage; optional counters checked when
// YSYX_23060124_WBU_PERF_EN is defined.
module tb_ysyx_23060124_wbu;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   retire_exp = 0;
  int   stall_exp  = 0;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_MRET  = 5'b00001;
  localparam logic [4:0] C_ECALL = 5'b00010;
  localparam logic [4:0] C_JALR  = 5'b00100;
  localparam logic [4:0] C_JAL   = 5'b01000;
  localparam logic [4:0] C_BRCH  = 5'b10000;

  ysyx_23060124_wbu_if bus();

  ysyx_23060124_wbu dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] src1,
                      input logic [31:0] res, input logic [4:0] rd, input logic rd_wen,
                      input logic [4:0] cls, input logic [31:0] mtvec, input logic [31:0] mepc,
                      input logic csr_wen, input logic [11:0] csr_addr, input logic [31:0] csr_wdata);
    bus.pc = pc;  bus.imm = imm;  bus.src1 = src1;  bus.res = res;
    bus.rd = rd;  bus.rd_wen = rd_wen;
    {bus.brch, bus.jal, bus.jalr, bus.ecall, bus.mret} = cls;
    bus.mtvec = mtvec;  bus.mepc = mepc;
    bus.csr_wen = csr_wen;  bus.csr_addr = csr_addr;  bus.csr_wdata = csr_wdata;
  endtask

  // Inputs after capture must not leak into the committed instruction.
  task automatic scramble();
    load(32'hDEAD_BEE0, 32'h1111_1110, 32'h2222_2222, 32'hFFFF_FFFE, 5'd31, 1'b1,
         C_JALR, 32'h3333_3330, 32'h4444_4444, 1'b1, 12'hFFF, 32'h5555_5555);
  endtask

  task automatic check_perf(input string name);
`ifdef YSYX_23060124_WBU_PERF_EN
    chk($sformatf("%s.retire_cnt", name), bus.retire_cnt, 64'(retire_exp));
    chk($sformatf("%s.stall_cnt", name), {32'd0, bus.stall_cnt}, 64'(stall_exp));
`else
    if (name.len() == 0) $display("empty tag");
`endif
  endtask

  // Issue the loaded instruction, hold IFU off for nwait cycles, check every cycle.
  task automatic run(input string name, input int nwait,
                     input logic e_rd_wen, input logic [4:0] e_rd, input logic [31:0] e_wdata,
                     input logic e_csr_wen, input logic [11:0] e_caddr, input logic [31:0] e_cdata,
                     input logic e_trap, input logic [31:0] e_mepc, input logic [31:0] e_npc);
    chk($sformatf("%s.idle_pre_ready", name), {63'd0, bus.pre_ready}, 64'd1);
    bus.pre_valid  = 1'b1;
    bus.post_ready = (nwait == 0);
    @(negedge clk);
    bus.pre_valid = 1'b0;
    scramble();
    retire_exp++;
    chk($sformatf("%s.commit_rd_wen", name), {63'd0, bus.wb_rd_wen}, {63'd0, e_rd_wen});
    if (e_rd_wen) begin
      chk($sformatf("%s.rd_addr", name), {59'd0, bus.wb_rd_addr}, {59'd0, e_rd});
      chk($sformatf("%s.rd_wdata", name), {32'd0, bus.wb_rd_wdata}, {32'd0, e_wdata});
    end
    chk($sformatf("%s.commit_csr_wen", name), {63'd0, bus.wb_csr_wen}, {63'd0, e_csr_wen});
    if (e_csr_wen) begin
      chk($sformatf("%s.csr_addr", name), {52'd0, bus.wb_csr_addr}, {52'd0, e_caddr});
      chk($sformatf("%s.csr_wdata", name), {32'd0, bus.wb_csr_wdata}, {32'd0, e_cdata});
    end
    chk($sformatf("%s.commit_trap_wen", name), {63'd0, bus.trap_wen}, {63'd0, e_trap});
    if (e_trap)
      chk($sformatf("%s.mepc_wdata", name), {32'd0, bus.mepc_wdata}, {32'd0, e_mepc});
    chk($sformatf("%s.npc", name), {32'd0, bus.npc}, {32'd0, e_npc});
    chk($sformatf("%s.commit_post_valid", name), {63'd0, bus.post_valid}, 64'd1);
    chk($sformatf("%s.commit_pre_ready", name), {63'd0, bus.pre_ready}, 64'd0);
    for (int k = 1; k <= nwait; k++) begin
      @(negedge clk);
      stall_exp++;
      chk($sformatf("%s.wait%0d_post_valid", name, k), {63'd0, bus.post_valid}, 64'd1);
      chk($sformatf("%s.wait%0d_pre_ready", name, k), {63'd0, bus.pre_ready}, 64'd0);
      chk($sformatf("%s.wait%0d_strobes", name, k),
          {61'd0, bus.wb_rd_wen, bus.wb_csr_wen, bus.trap_wen}, 64'd0);
      chk($sformatf("%s.wait%0d_npc", name, k), {32'd0, bus.npc}, {32'd0, e_npc});
      if (k == nwait) bus.post_ready = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("%s.done_post_valid", name), {63'd0, bus.post_valid}, 64'd0);
    chk($sformatf("%s.done_pre_ready", name), {63'd0, bus.pre_ready}, 64'd1);
    chk($sformatf("%s.done_strobes", name),
        {61'd0, bus.wb_rd_wen, bus.wb_csr_wen, bus.trap_wen}, 64'd0);
    $display("txn %s: npc=0x%08h waits=%0d", name, bus.npc, nwait);
  endtask

  initial begin
    rst = 1'b1;
    bus.pre_valid  = 1'b0;
    bus.post_ready = 1'b0;
    load('0, '0, '0, '0, '0, 1'b0, C_NONE, '0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset.pre_ready", {63'd0, bus.pre_ready}, 64'd1);
    chk("reset.post_valid", {63'd0, bus.post_valid}, 64'd0);
    chk("reset.npc", {32'd0, bus.npc}, 64'd0);
    chk("reset.strobes", {61'd0, bus.wb_rd_wen, bus.wb_csr_wen, bus.trap_wen}, 64'd0);
    check_perf("reset");
    rst = 1'b0;
    @(negedge clk);

    // addi x5 retire
    load(32'h8000_0000, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, C_NONE, '0, '0, 1'b0, '0, '0);
    run("addi", 0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, '0, '0, 1'b0, '0, 32'h8000_0004);

    // write to x0 is suppressed
    load(32'h8000_0004, 32'h0, 32'h0, 32'h0000_0055, 5'd0, 1'b1, C_NONE, '0, '0, 1'b0, '0, '0);
    run("rd0", 0, 1'b0, 5'd0, 32'h0, 1'b0, '0, '0, 1'b0, '0, 32'h8000_0008);

    load(32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 32'h1, 5'd0, 1'b0, C_BRCH, '0, '0, 1'b0, '0, '0);
    run("beq_taken", 0, 1'b0, 5'd0, 32'h0, 1'b0, '0, '0, 1'b0, '0, 32'h8000_0000);

    load(32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 32'h0, 5'd0, 1'b0, C_BRCH, '0, '0, 1'b0, '0, '0);
    run("beq_not", 0, 1'b0, 5'd0, 32'h0, 1'b0, '0, '0, 1'b0, '0, 32'h8000_0014);

    load(32'h8000_0020, 32'h2, 32'h8000_0101, 32'h8000_0024, 5'd1, 1'b1, C_JALR, '0, '0,
         1'b0, '0, '0);
    run("jalr_wait3", 3, 1'b1, 5'd1, 32'h8000_0024, 1'b0, '0, '0, 1'b0, '0, 32'h8000_0102);

    load(32'h8000_0100, 32'h20, 32'h0, 32'h8000_0104, 5'd2, 1'b1, C_JAL, '0, '0, 1'b0, '0, '0);
    run("jal", 1, 1'b1, 5'd2, 32'h8000_0104, 1'b0, '0, '0, 1'b0, '0, 32'h8000_0120);

    // pc+imm wraps around 2^32
    load(32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 5'd0, 1'b0, C_JAL, '0, '0, 1'b0, '0, '0);
    run("jal_wrap", 0, 1'b0, 5'd0, 32'h0, 1'b0, '0, '0, 1'b0, '0, 32'h0000_0010);

    load(32'h8000_0030, 32'h0, 32'h0, 32'h0000_0088, 5'd7, 1'b1, C_NONE, '0, '0,
         1'b1, 12'h305, 32'h0000_0ABC);
    run("csrrw", 0, 1'b1, 5'd7, 32'h0000_0088, 1'b1, 12'h305, 32'h0000_0ABC, 1'b0, '0,
        32'h8000_0034);

    load(32'h8000_0040, 32'h0, 32'h0, 32'h0000_0077, 5'd3, 1'b1, C_ECALL, 32'h8000_1000,
         32'h0, 1'b0, '0, '0);
    run("ecall", 2, 1'b1, 5'd3, 32'h0000_0077, 1'b0, '0, '0, 1'b1, 32'h8000_0040,
        32'h8000_1000);

    load(32'h8000_1010, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, C_MRET, 32'h8000_1000, 32'h8000_0044,
         1'b0, '0, '0);
    run("mret", 0, 1'b0, 5'd0, 32'h0, 1'b0, '0, '0, 1'b0, '0, 32'h8000_0044);
    check_perf("after_run");

    // reset while waiting on IFU discards the instruction
    load(32'h8000_0200, 32'h0, 32'h0, 32'h99, 5'd9, 1'b1, C_NONE, '0, '0, 1'b0, '0, '0);
    bus.pre_valid  = 1'b1;
    bus.post_ready = 1'b0;
    @(negedge clk);
    bus.pre_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait.in_wait", {63'd0, bus.post_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    retire_exp = 0;
    stall_exp  = 0;
    chk("rst_wait.pre_ready", {63'd0, bus.pre_ready}, 64'd1);
    chk("rst_wait.post_valid", {63'd0, bus.post_valid}, 64'd0);
    chk("rst_wait.npc", {32'd0, bus.npc}, 64'd0);
    chk("rst_wait.strobes", {61'd0, bus.wb_rd_wen, bus.wb_csr_wen, bus.trap_wen}, 64'd0);
    check_perf("rst_wait");

    // reset beats a simultaneous handshake
    bus.pre_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.pre_valid = 1'b0;
    chk("rst_hs.post_valid", {63'd0, bus.post_valid}, 64'd0);
    chk("rst_hs.strobes", {61'd0, bus.wb_rd_wen, bus.wb_csr_wen, bus.trap_wen}, 64'd0);
    @(negedge clk);
    chk("rst_hs.still_idle", {63'd0, bus.post_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
